mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the five-stage ARM pipeline, directly downstream of the execute stage's pipeline register. It takes the ALU result as a data address and `val_Rm` as store data, and performs 32-bit loads and stores against the board's 16-bit asynchronous SRAM as two halfword accesses. While an access is in flight it deasserts `ready`; the hazard/freeze logic uses this to stall every upstream pipeline register. Loaded data is returned on `mem_result` for the MEM/WB register.

## Interface
Parameters:
- `SRAM_WAIT`, 2: cycles each halfword access is held on the SRAM bus; minimum 1.
- `ADDR_W`, 18: SRAM halfword address width.

Ports:
- `clk` in 1: the single clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_r_en` in 1: load request from the EXE/MEM register.
- `mem_w_en` in 1: store request from the EXE/MEM register.
- `alu_res` in 32: byte address, always word aligned.
- `val_Rm` in 32: store data.
- `mem_result` out 32: last completed load word.
- `ready` out 1: high when the pipeline may advance.
- `sram_addr` out ADDR_W: SRAM halfword address.
- `sram_dq_out` out 16: write data driven to the SRAM.
- `sram_dq_oe` out 1: tri-state enable for `sram_dq_out`; the pad ring handles the tri-state.
- `sram_dq_in` in 16: read data from the SRAM.
- `sram_we_n` out 1: active-low write enable.

## Operation
- Request: `req = mem_r_en | mem_w_en`.
  - If both enables are high, the request is treated as a store.
- Effective address: `eff = alu_res - MEM_BASE` (32-bit wrap) with the offset macro defined, otherwise `eff = alu_res`.
  - Low halfword is at `{eff[18:2],1'b0}`; high halfword is at `{eff[18:2],1'b1}`.
  - `eff[1:0]` and `eff[31:19]` are ignored.
- FSM states: `IDLE`, `ACC_LO`, `ACC_HI`, `DONE`.
  - `IDLE`: when `req` is high, go to `ACC_LO`, latch `eff`, `val_Rm` and `is_write`, and load the counter with `SRAM_WAIT-1`.
  - `ACC_LO`: drive the low address. On a store, also drive `val_Rm[15:0]` with `sram_dq_oe=1` and `sram_we_n=0`. When the counter reaches 0, capture `sram_dq_in` into `lo` on a load, reload the counter, and go to `ACC_HI`.
  - `ACC_HI`: same as `ACC_LO`, using the high address, `val_Rm[31:16]` and `hi`. When the counter reaches 0, go to `DONE`.
  - `DONE`: on a load, `mem_result <= {hi, lo}`. Go unconditionally to `IDLE`. The still-present request is not restarted.
- `ready`:
  - Combinational `!req` in `IDLE`.
  - 1 in `DONE`.
  - 0 in `ACC_LO` and `ACC_HI`.
- `mem_result` holds its value across stores and idle cycles.
- Outside an active store cycle: `sram_we_n=1` and `sram_dq_oe=0`.
- `sram_addr` holds its last value in `IDLE`.

## Timing
- Reset values: state `IDLE`, `mem_result=0`, `sram_addr=0`, `sram_dq_out=0`, `sram_dq_oe=0`, `sram_we_n=1`, counter 0.
  - `ready` follows `!req` immediately after reset.
- Busy window per access: `2*SRAM_WAIT` cycles with `ready=0`, then one `DONE` cycle with `ready=1`.
  - The pipeline advances on the `DONE` edge.
  - Total: `2*SRAM_WAIT+1` cycles, i.e. 5 at the default.
- `ready` drops in the same cycle the request appears (combinational), so the upstream registers freeze on that edge.
- Load data is valid on `mem_result` in the cycle after `DONE`, when the MEM/WB register samples it.
- Back-to-back memory instructions: `IDLE` is revisited for exactly one cycle between them. In that cycle `ready=0`, because the next `req` is already present.
- `rst` asserted mid-access: state returns to `IDLE` and `sram_we_n=1`. A partial store is left in SRAM and is not rolled back.
- Counter width: `$clog2(SRAM_WAIT+1)`.

## Configuration
- `MEM_ADDR_OFFSET_EN` defined: `MEM_BASE` (1024) is subtracted from `alu_res` before address mapping, so data memory starts at byte 1024 in the ISA view.
- Not defined: `alu_res` maps to SRAM directly and no subtractor is synthesised.

## Structure
- Package `mem_pkg` holds:
  - the `mem_state_t` enum (`IDLE`, `ACC_LO`, `ACC_HI`, `DONE`);
  - `MEM_BASE = 32'd1024`;
  - the SRAM width constant 16.
- Sub-module `sram_ctrl` contains the FSM, the counter and the SRAM pins.
  - `mem_stage` contains only the address mapping, request decode and `mem_result` register.

## Test plan
- Store, offset enabled, `alu_res=1028`, `val_Rm=32'hDEADBEEF`:
  - halfword 2 is written with `BEEF`, then halfword 3 with `DEAD`;
  - `sram_we_n` is low for 2 cycles per half;
  - `ready` is low for 4 cycles, then high for 1 cycle.
- Load of the same address, SRAM model returning the stored data: `mem_result=32'hDEADBEEF` the cycle after `DONE`, with no `sram_we_n` pulse.
- Back-to-back store then load at 1032:
  - exactly one `IDLE` cycle between the accesses, with `ready=0`;
  - the second access starts at halfword 4.
- No request for 10 cycles: `ready=1` throughout; `sram_we_n=1`; `mem_result` is unchanged.
- `rst` during `ACC_HI` of a store: the next cycle shows `IDLE`, `sram_we_n=1`, `sram_dq_oe=0`, `mem_result=0`.
- `mem_r_en=mem_w_en=1` at `alu_res=1024`: executed as a store to halfwords 0 and 1, and `mem_result` is not updated.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage and its SRAM controller.
// The package is named mem_pkg and is imported by mem_stage and sram_ctrl.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC_LO,
    ACC_HI,
    DONE
  } mem_state_t;

  localparam logic [31:0] MEM_BASE = 32'd1024;
  localparam int          SRAM_DW  = 16;

endpackage

// File: rtl/mem_stage_sram_ctrl.sv
// SRAM controller: splits one 32-bit access into two halfword cycles on the async SRAM.
// All SRAM pins are registered, so each pin value lines up with the state that drives it.
module sram_ctrl
  import mem_pkg::*;
#(
  parameter int SRAM_WAIT = 2,
  parameter int ADDR_W    = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                is_write,
  input  logic [ADDR_W-2:0]   word_addr,
  input  logic [31:0]         wdata,
  output logic                ready,
  output logic                load_done,
  output logic [31:0]         load_data,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [SRAM_DW-1:0]  sram_dq_out,
  output logic                sram_dq_oe,
  input  logic [SRAM_DW-1:0]  sram_dq_in,
  output logic                sram_we_n
);

  localparam int               CNT_W      = $clog2(SRAM_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SRAM_WAIT - 1);

  mem_state_t          state;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-2:0]   word_q;
  logic [31:0]         wdata_q;
  logic                write_q;
  logic [SRAM_DW-1:0]  lo;
  logic [SRAM_DW-1:0]  hi;
  logic                cnt_zero;

  assign cnt_zero = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state       <= ACC_LO;
            cnt         <= CNT_RELOAD;
            sram_addr   <= {word_addr, 1'b0};
            sram_dq_out <= wdata[15:0];
            sram_dq_oe  <= is_write;
            sram_we_n   <= !is_write;
          end
        end
        ACC_LO: begin
          if (cnt_zero) begin
            state       <= ACC_HI;
            cnt         <= CNT_RELOAD;
            sram_addr   <= {word_q, 1'b1};
            sram_dq_out <= wdata_q[31:16];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACC_HI: begin
          if (cnt_zero) begin
            state      <= DONE;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: pure data registers carry no reset; they are always written before the FSM consumes them.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      word_q  <= word_addr;
      wdata_q <= wdata;
      write_q <= is_write;
    end
    if (state == ACC_LO && cnt_zero && !write_q) lo <= sram_dq_in;
    if (state == ACC_HI && cnt_zero && !write_q) hi <= sram_dq_in;
  end

  // ready drops combinationally in IDLE so the upstream registers freeze on the request edge.
  always_comb begin
    ready = 1'b0;
    case (state)
      IDLE:    ready = !req;
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign load_done = (state == DONE) && !write_q;
  assign load_data = {hi, lo};

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the ARM pipeline: address mapping, request decode and the load result register.
// Define MEM_ADDR_OFFSET_EN to subtract MEM_BASE from the ALU address before SRAM mapping.
module mem_stage
  import mem_pkg::*;
#(
  parameter int SRAM_WAIT = 2,
  parameter int ADDR_W    = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_r_en,
  input  logic                mem_w_en,
  input  logic [31:0]         alu_res,
  input  logic [31:0]         val_Rm,
  output logic [31:0]         mem_result,
  output logic                ready,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [SRAM_DW-1:0]  sram_dq_out,
  output logic                sram_dq_oe,
  input  logic [SRAM_DW-1:0]  sram_dq_in,
  output logic                sram_we_n
);

  logic [31:0] eff;
  logic        req;
  logic        is_write;
  logic        load_done;
  logic [31:0] load_data;
  logic        unused_eff_bits;

`ifdef MEM_ADDR_OFFSET_EN
  assign eff = alu_res - MEM_BASE;
`else
  assign eff = alu_res;
`endif

  // Both enables high is a store; the write enable wins.
  assign req      = mem_r_en | mem_w_en;
  assign is_write = mem_w_en;

  assign unused_eff_bits = ^{eff[31:ADDR_W+1], eff[1:0]};

  sram_ctrl #(
    .SRAM_WAIT (SRAM_WAIT),
    .ADDR_W    (ADDR_W)
  ) u_sram_ctrl (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .is_write    (is_write),
    .word_addr   (eff[ADDR_W:2]),
    .wdata       (val_Rm),
    .ready       (ready),
    .load_done   (load_done),
    .load_data   (load_data),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n)
  );

  always_ff @(posedge clk) begin
    if (rst)            mem_result <= '0;
    else if (load_done) mem_result <= load_data;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a behavioural 16-bit async SRAM.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_mem_stage;

`ifdef MEM_ADDR_OFFSET_EN
  localparam logic [31:0] BASE = 32'd1024;
`else
  localparam logic [31:0] BASE = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] alu_res, val_Rm;
  logic [31:0] mem_result;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  logic [15:0] sram [0:(1<<18)-1];

  int n_checks = 0;
  int n_fail   = 0;

  int          n_busy, n_we_lo, n_we_hi, n_we_any;
  logic [17:0] first_addr;
  logic        done_seen;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk         (clk),
    .rst         (rst),
    .mem_r_en    (mem_r_en),
    .mem_w_en    (mem_w_en),
    .alu_res     (alu_res),
    .val_Rm      (val_Rm),
    .mem_result  (mem_result),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n)
  );

  always @(posedge clk) if (!sram_we_n) sram[sram_addr] <= sram_dq_out;
  assign sram_dq_in = sram[sram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] hw_lo(input logic [31:0] a);
    logic [31:0] e;
    e = a - BASE;
    return {e[18:2], 1'b0};
  endfunction

  // Runs one access starting in an IDLE cycle; returns just after the DONE edge without dropping the request.
  task automatic run_access(input string tag, input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] d);
    logic [17:0] lo_a;
    lo_a = hw_lo(a);
    n_busy = 0; n_we_lo = 0; n_we_hi = 0; n_we_any = 0;
    first_addr = '0; done_seen = 1'b0;
    mem_r_en = r; mem_w_en = w; alu_res = a; val_Rm = d;
    @(negedge clk);
    check({tag, "_idle_ready"}, 32'(ready), 32'd0);
    for (int i = 0; i < 20 && !done_seen; i++) begin
      @(negedge clk);
      if (ready) begin
        done_seen = 1'b1;
      end else begin
        n_busy++;
        if (i == 0) first_addr = sram_addr;
        if (!sram_we_n) n_we_any++;
        if (!sram_we_n && sram_dq_oe && sram_addr == lo_a && sram_dq_out == d[15:0]) n_we_lo++;
        if (!sram_we_n && sram_dq_oe && sram_addr == (lo_a | 18'd1) && sram_dq_out == d[31:16]) n_we_hi++;
      end
    end
    check({tag, "_done_seen"}, 32'(done_seen), 32'd1);
    check({tag, "_busy_cycles"}, n_busy, 32'd4);
    check({tag, "_first_addr"}, 32'(first_addr), 32'(lo_a));
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; alu_res = '0; val_Rm = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready",      32'(ready),       32'd1);
    check("rst_we_n",       32'(sram_we_n),   32'd1);
    check("rst_oe",         32'(sram_dq_oe),  32'd0);
    check("rst_addr",       32'(sram_addr),   32'd0);
    check("rst_dq_out",     32'(sram_dq_out), 32'd0);
    check("rst_mem_result", mem_result,       32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Store DEADBEEF at 1028.
    run_access("st1", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    mem_w_en = 1'b0;
    check("st1_we_lo", n_we_lo, 32'd2);
    check("st1_we_hi", n_we_hi, 32'd2);
    check("st1_sram_lo", 32'(sram[hw_lo(32'd1028)]),          32'h0000BEEF);
    check("st1_sram_hi", 32'(sram[hw_lo(32'd1028) | 18'd1]),  32'h0000DEAD);
    @(negedge clk);
    check("st1_mem_result_held", mem_result, 32'd0);
    @(posedge clk); #1;

    // Load it back.
    run_access("ld1", 1'b1, 1'b0, 32'd1028, 32'h0);
    mem_r_en = 1'b0;
    check("ld1_no_we", n_we_any, 32'd0);
    @(negedge clk);
    check("ld1_mem_result", mem_result, 32'hDEADBEEF);
    @(posedge clk); #1;

    // Back-to-back store then load at 1032.
    run_access("st2", 1'b0, 1'b1, 32'd1032, 32'hA5A55A5A);
    check("st2_we_lo", n_we_lo, 32'd2);
    check("st2_we_hi", n_we_hi, 32'd2);
    run_access("ld2", 1'b1, 1'b0, 32'd1032, 32'h0);
    mem_r_en = 1'b0;
    check("ld2_no_we", n_we_any, 32'd0);
    @(negedge clk);
    check("ld2_mem_result", mem_result, 32'hA5A55A5A);
    @(posedge clk); #1;

    // Ten idle cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", 32'(ready),     32'd1);
      check("idle_we_n",  32'(sram_we_n), 32'd1);
      check("idle_result", mem_result,    32'hA5A55A5A);
    end
    @(posedge clk); #1;

    // Reset during ACC_HI of a store.
    mem_w_en = 1'b1; alu_res = 32'd1040; val_Rm = 32'h11112222;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rstmid_in_hi_addr", 32'(sram_addr), 32'(hw_lo(32'd1040) | 18'd1));
    check("rstmid_in_hi_we_n", 32'(sram_we_n), 32'd0);
    rst = 1'b1; mem_w_en = 1'b0;
    @(negedge clk);
    check("rstmid_ready",      32'(ready),      32'd1);
    check("rstmid_we_n",       32'(sram_we_n),  32'd1);
    check("rstmid_oe",         32'(sram_dq_oe), 32'd0);
    check("rstmid_mem_result", mem_result,      32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Both enables: executed as a store, result register untouched.
    run_access("both", 1'b1, 1'b1, 32'd1024, 32'h12345678);
    mem_r_en = 1'b0; mem_w_en = 1'b0;
    check("both_we_lo", n_we_lo, 32'd2);
    check("both_we_hi", n_we_hi, 32'd2);
    check("both_sram_lo", 32'(sram[hw_lo(32'd1024)]),         32'h00005678);
    check("both_sram_hi", 32'(sram[hw_lo(32'd1024) | 18'd1]), 32'h00001234);
    @(negedge clk);
    check("both_mem_result", mem_result, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
